// File: rtl/tdc_meas_scheduler_if.sv
// Measurement input and byte-stream output of the TDC scheduler.
// The slave modport is the scheduler's view; the master modport is the TDC/UART side.
interface tdc_meas_scheduler_if #(
    parameter int COUNT_W = 32
);
    logic               meas_valid;
    logic [COUNT_W-1:0] meas_count;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output meas_valid, meas_count, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  meas_valid, meas_count, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/tdc_meas_scheduler.sv
// Arms the TDC with a post-capture holdoff, queues results, and frames each one as
// SYNC, payload bytes LSB first, XOR checksum over a valid/ready byte stream.
module tdc_meas_scheduler #(
    parameter int         COUNT_W     = 32,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLDOFF_CYC = 20,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                i_clk_200m,
    input  logic                i_rst,
    tdc_meas_scheduler_if.slave bus,
    output logic                o_tdc_arm,
    output logic [7:0]          o_drop_cnt,
    output logic                o_busy
);
    localparam int NB = COUNT_W / 8;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);

    typedef enum logic [1:0] {ARM_INIT, ARMED, HOLDOFF, WAIT_SPACE} arm_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SYNC, T_DATA, T_CSUM} tx_state_t;

    arm_state_t         r_arm_state, w_arm_next;
    tx_state_t          r_tx_state, w_tx_next;
    logic [HW-1:0]      r_hold_cnt;
    logic [7:0]         r_drop_cnt;

    logic [COUNT_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_fifo_count;

    logic [COUNT_W-1:0] r_shift;
    logic [7:0]         r_csum;
    logic [IW-1:0]      r_byte_idx;

    logic               w_push, w_pop;
    logic [AW:0]        w_count_after_pop;

    assign w_push            = (r_arm_state == ARMED) && bus.meas_valid;
    assign w_pop             = (r_tx_state == T_IDLE) && (r_fifo_count != '0);
    assign w_count_after_pop = r_fifo_count - {{AW{1'b0}}, w_pop};

    // Result FIFO: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk_200m) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= bus.meas_count;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + 1'b1;
            else if (!w_push && w_pop) r_fifo_count <= r_fifo_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk_200m) begin
        if (i_rst) r_arm_state <= ARM_INIT;
        else       r_arm_state <= w_arm_next;
    end

    // Re-arm only when a push could not overflow the FIFO.
    always_comb begin
        w_arm_next = r_arm_state;
        case (r_arm_state)
            ARM_INIT:   w_arm_next = ARMED;
            ARMED:      if (bus.meas_valid) w_arm_next = HOLDOFF;
            HOLDOFF:    if (r_hold_cnt == '0)
                            w_arm_next = (w_count_after_pop < FULL_CNT) ? ARMED : WAIT_SPACE;
            WAIT_SPACE: if (r_fifo_count != FULL_CNT) w_arm_next = ARMED;
            default:    w_arm_next = ARM_INIT;
        endcase
    end

    always_comb begin
        o_tdc_arm = (r_arm_state == ARMED);
    end

    always_ff @(posedge i_clk_200m) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push)
                r_hold_cnt <= HOLD_LOAD;
            else if (r_arm_state == HOLDOFF && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - 1'b1;
            if (bus.meas_valid && r_arm_state != ARMED && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk_200m) begin
        if (i_rst) r_tx_state <= T_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            T_IDLE:  if (r_fifo_count != '0) w_tx_next = T_SYNC;
            T_SYNC:  if (bus.tx_ready) w_tx_next = T_DATA;
            T_DATA:  if (bus.tx_ready && r_byte_idx == LAST_IDX) w_tx_next = T_CSUM;
            T_CSUM:  if (bus.tx_ready) w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    // Payload shifts out LSB first; checksum accumulates as each byte is accepted.
    always_ff @(posedge i_clk_200m) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_csum     <= '0;
            r_byte_idx <= '0;
        end else if (w_pop) begin
            r_shift    <= r_fifo_mem[r_rd_ptr];
            r_csum     <= '0;
            r_byte_idx <= '0;
        end else if (r_tx_state == T_DATA && bus.tx_ready) begin
            r_shift    <= r_shift >> 8;
            r_csum     <= r_csum ^ r_shift[7:0];
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    always_comb begin
        bus.tx_valid = (r_tx_state != T_IDLE);
        bus.tx_data  = 8'h00;
        case (r_tx_state)
            T_SYNC:  bus.tx_data = SYNC_BYTE;
            T_DATA:  bus.tx_data = r_shift[7:0];
            T_CSUM:  bus.tx_data = r_csum;
            default: bus.tx_data = 8'h00;
        endcase
    end

    assign o_drop_cnt = r_drop_cnt;
    assign o_busy     = (r_fifo_count != '0) || (r_tx_state != T_IDLE);
endmodule

// File: tb/tb_tdc_meas_scheduler.sv
// Directed bench for tdc_meas_scheduler: frame vectors from a table, then
// sequences for holdoff drops, FIFO fill/drain, push+pop overlap and mid-frame reset.
`timescale 1ns/1ps
module tb_tdc_meas_scheduler;
    logic       clk_200m = 1'b0;
    logic       rst;
    logic       tdc_arm;
    logic [7:0] drop_cnt;
    logic       busy;

    tdc_meas_scheduler_if #(.COUNT_W(32)) bus();

    tdc_meas_scheduler #(
        .COUNT_W(32), .FIFO_DEPTH(4), .HOLDOFF_CYC(20), .SYNC_BYTE(8'hA5)
    ) dut (
        .i_clk_200m(clk_200m),
        .i_rst     (rst),
        .bus       (bus),
        .o_tdc_arm (tdc_arm),
        .o_drop_cnt(drop_cnt),
        .o_busy    (busy)
    );

    always #2.5 clk_200m = ~clk_200m;

    typedef struct packed {
        logic [31:0] meas;
        logic        toggle;
        logic [47:0] exp;
    } vec_t;

    vec_t       vecs [5];
    int         tests = 0;
    int         fails = 0;
    int         low_cnt = 0;
    int         stable_err = 0;
    logic [7:0] rx [64];
    int         rx_n = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200m);
        #1;
        if (!tdc_arm) low_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [31:0] m);
        bus.meas_count = m;
        bus.meas_valid = 1'b1;
        tick();
        bus.meas_valid = 1'b0;
    endtask

    task automatic wait_arm();
        int n = 0;
        while (!tdc_arm && n < 200) begin
            tick();
            n++;
        end
        if (!tdc_arm) chk("wait_arm_timeout", 48'(tdc_arm), 48'd1);
    endtask

    // Accepts n bytes; ready is 1 or alternates 0/1. Data must hold while stalled.
    task automatic collect(input int n, input bit toggle);
        int         cyc = 0;
        int         got = 0;
        logic [7:0] prev = 8'h00;
        bit         hold = 1'b0;
        while (got < n && cyc < 500) begin
            if (hold && bus.tx_data !== prev) stable_err++;
            bus.tx_ready = toggle ? cyc[0] : 1'b1;
            if (bus.tx_valid && bus.tx_ready && rx_n < 64) begin
                rx[rx_n] = bus.tx_data;
                rx_n++;
                got++;
            end
            hold = bus.tx_valid && !bus.tx_ready;
            prev = bus.tx_data;
            tick();
            cyc++;
        end
        bus.tx_ready = 1'b0;
        if (got < n) chk("collect_timeout", 48'(got), 48'(n));
    endtask

    function automatic logic [47:0] rx_frame(input int b);
        return {rx[b], rx[b+1], rx[b+2], rx[b+3], rx[b+4], rx[b+5]};
    endfunction

    function automatic logic [47:0] frame48(input logic [31:0] m);
        return {8'hA5, m[7:0], m[15:8], m[23:16], m[31:24],
                m[7:0] ^ m[15:8] ^ m[23:16] ^ m[31:24]};
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        logic [31:0] t3_base;
        rst            = 1'b1;
        bus.meas_valid = 1'b0;
        bus.meas_count = '0;
        bus.tx_ready   = 1'b0;

        vecs[0] = '{32'h00000028, 1'b0, 48'hA5_28_00_00_00_28};
        vecs[1] = '{32'h12345678, 1'b1, 48'hA5_78_56_34_12_08};
        vecs[2] = '{32'hFFFFFFFF, 1'b0, 48'hA5_FF_FF_FF_FF_00};
        vecs[3] = '{32'h80000001, 1'b0, 48'hA5_01_00_00_80_81};
        vecs[4] = '{32'hDEADBEEF, 1'b1, 48'hA5_EF_BE_AD_DE_22};

        idle(3);
        chk("rst_arm",      48'(tdc_arm),      48'd0);
        chk("rst_tx_valid", 48'(bus.tx_valid), 48'd0);
        chk("rst_tx_data",  48'(bus.tx_data),  48'd0);
        chk("rst_drop",     48'(drop_cnt),     48'd0);
        chk("rst_busy",     48'(busy),         48'd0);
        rst = 1'b0;
        tick();
        chk("arm_after_rst", 48'(tdc_arm), 48'd1);

        for (int v = 0; v < 5; v++) begin
            wait_arm();
            low_cnt    = 0;
            stable_err = 0;
            rx_n       = 0;
            pulse(vecs[v].meas);
            chk($sformatf("v%0d_push_vld", v),  48'(bus.tx_valid), 48'd0);
            chk($sformatf("v%0d_push_busy", v), 48'(busy),         48'd1);
            tick();
            chk($sformatf("v%0d_sync_vld", v),  48'(bus.tx_valid), 48'd1);
            chk($sformatf("v%0d_sync_dat", v),  48'(bus.tx_data),  48'hA5);
            collect(6, vecs[v].toggle);
            chk($sformatf("v%0d_frame", v),  rx_frame(0),        vecs[v].exp);
            chk($sformatf("v%0d_stable", v), 48'(stable_err),    48'd0);
            wait_arm();
            chk($sformatf("v%0d_holdoff", v), 48'(low_cnt),      48'd20);
            chk($sformatf("v%0d_idle", v),    48'(busy),         48'd0);
        end

        // Capture during holdoff is dropped, not queued.
        rx_n = 0;
        pulse(32'h00C0FFEE);
        idle(4);
        bus.meas_valid = 1'b1;
        tick();
        bus.meas_valid = 1'b0;
        chk("t4_drop_one", 48'(drop_cnt), 48'd1);
        collect(6, 1'b0);
        chk("t4_frame", rx_frame(0), frame48(32'h00C0FFEE));
        nv = 0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.tx_valid) nv++;
            tick();
        end
        bus.tx_ready = 1'b0;
        chk("t4_no_extra_frame", 48'(nv), 48'd0);

        // Stalled UART: one frame in flight plus four queued, then drops.
        t3_base = 32'h0A0B0C00;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_arm_cap%0d", i), 48'(tdc_arm), 48'd1);
            pulse(t3_base + 32'(i));
            idle(29);
        end
        chk("t3_arm_full",  48'(tdc_arm),      48'd0);
        chk("t3_busy",      48'(busy),         48'd1);
        chk("t3_stuck_vld", 48'(bus.tx_valid), 48'd1);
        chk("t3_stuck_dat", 48'(bus.tx_data),  48'hA5);
        pulse(32'hBAD0BAD0);
        chk("t3_drop", 48'(drop_cnt), 48'd2);
        bus.meas_valid = 1'b1;
        idle(300);
        bus.meas_valid = 1'b0;
        chk("t3_drop_sat", 48'(drop_cnt), 48'd255);
        chk("t3_arm_still_low", 48'(tdc_arm), 48'd0);
        rx_n = 0;
        collect(6, 1'b0);
        chk("t3_idle_gap", 48'(bus.tx_valid), 48'd0);
        chk("t3_arm_prepop", 48'(tdc_arm), 48'd0);
        tick();
        chk("t3_pop_vld", 48'(bus.tx_valid), 48'd1);
        chk("t3_arm_at_pop", 48'(tdc_arm), 48'd0);
        tick();
        chk("t3_arm_after_pop", 48'(tdc_arm), 48'd1);
        collect(24, 1'b0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t3_frame%0d", i), rx_frame(6 * i), frame48(t3_base + 32'(i)));

        // Push and pop on the same edge with two entries queued.
        wait_arm();
        pulse(32'hCAFE0001);
        idle(29);
        chk("t6_arm_q", 48'(tdc_arm), 48'd1);
        pulse(32'hCAFE0002);
        idle(29);
        chk("t6_arm_r", 48'(tdc_arm), 48'd1);
        pulse(32'hCAFE0003);
        idle(29);
        rx_n = 0;
        collect(6, 1'b0);
        chk("t6_idle", 48'(bus.tx_valid), 48'd0);
        chk("t6_arm_s", 48'(tdc_arm), 48'd1);
        pulse(32'hCAFE0004);
        chk("t6_count", 48'(dut.r_fifo_count), 48'd2);
        chk("t6_pop_vld", 48'(bus.tx_valid), 48'd1);
        collect(18, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_frame%0d", i), rx_frame(6 * i), frame48(32'hCAFE0001 + 32'(i)));

        // Reset after the second byte of a frame, two entries queued.
        wait_arm();
        pulse(32'h55AA1234);
        idle(29);
        pulse(32'h55AA5678);
        idle(29);
        pulse(32'h55AA9ABC);
        idle(29);
        bus.tx_ready = 1'b1;
        tick();
        tick();
        bus.tx_ready = 1'b0;
        chk("t5_mid_dat",  48'(bus.tx_data), 48'h12);
        chk("t5_mid_busy", 48'(busy),        48'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_vld",   48'(bus.tx_valid),     48'd0);
        chk("t5_rst_busy",  48'(busy),             48'd0);
        chk("t5_rst_drop",  48'(drop_cnt),         48'd0);
        chk("t5_rst_arm",   48'(tdc_arm),          48'd0);
        chk("t5_rst_count", 48'(dut.r_fifo_count), 48'd0);
        rst = 1'b0;
        tick();
        chk("t5_arm_after", 48'(tdc_arm), 48'd1);
        nv = 0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_valid) nv++;
            tick();
        end
        bus.tx_ready = 1'b0;
        chk("t5_no_resume", 48'(nv),   48'd0);
        chk("t5_idle_busy", 48'(busy), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
